// File: rtl/arm_pipeline_pkg.sv
// Shared pipeline definitions: word width, the NOP encoding, the fetch-entry
// layout and the per-cycle operation code used by the IF/ID prefetch queue.
package arm_pipeline_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instruction;
  } fetch_entry_t;

  // Net effect of one cycle on the queue bookkeeping.
  typedef enum logic [2:0] {
    Q_OP_IDLE,
    Q_OP_PUSH,
    Q_OP_POP,
    Q_OP_PUSH_POP,
    Q_OP_FLUSH
  } queue_op_e;

  // Flush dominates; otherwise combine push/pop into a single operation.
  function automatic queue_op_e queue_op(input logic push, input logic pop, input logic flush);
    queue_op_e op;
    if (flush)             op = Q_OP_FLUSH;
    else if (push && pop)  op = Q_OP_PUSH_POP;
    else if (push)         op = Q_OP_PUSH;
    else if (pop)          op = Q_OP_POP;
    else                   op = Q_OP_IDLE;
    return op;
  endfunction

endpackage

// File: rtl/if_id_prefetch_queue_mem.sv
// Entry storage for the prefetch queue: DEPTH x DATA_W registers, one
// synchronous write port and one asynchronous read port. Contents are not reset.
module prefetch_queue_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] storage [DEPTH];

  // Write the addressed entry on a push; no reset so the array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (we) storage[waddr] <= wdata;
  end

  // Asynchronous read of the head entry.
  always_comb begin
    rdata = storage[raddr];
  end

endmodule

// File: rtl/if_id_prefetch_queue.sv
// IF/ID decoupling queue: buffers up to DEPTH {pc, instruction} pairs between
// fetch and decode, back-pressures fetch when full and empties on a branch flush.
module if_id_prefetch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WORD_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WORD_W-1:0]          in_pc,
  input  logic [WORD_W-1:0]          in_instruction,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       freeze,
  output logic                       out_valid,
  output logic [WORD_W-1:0]          out_pc,
  output logic [WORD_W-1:0]          out_instruction,
  output logic [$clog2(DEPTH):0]     count
);

  import arm_pipeline_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    rptr;
  logic [PTR_W-1:0]    wptr;
  logic                push;
  logic                pop;
  queue_op_e           op;
  logic [2*WORD_W-1:0] head_data;

  // Handshake flags come from the registered count only, so there is no
  // combinational path from in_valid or freeze to in_ready.
  always_comb begin
    in_ready  = (count != CNT_W'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & ~freeze & ~flush;
    op        = queue_op(push, pop, flush);
  end

  // Pointer and occupancy bookkeeping; reset has priority, then flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      case (op)
        Q_OP_FLUSH: begin
          rptr  <= '0;
          wptr  <= '0;
          count <= '0;
        end
        Q_OP_PUSH: begin
          wptr  <= wptr + PTR_W'(1);
          count <= count + CNT_W'(1);
        end
        Q_OP_POP: begin
          rptr  <= rptr + PTR_W'(1);
          count <= count - CNT_W'(1);
        end
        Q_OP_PUSH_POP: begin
          wptr <= wptr + PTR_W'(1);
          rptr <= rptr + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  prefetch_queue_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (2 * WORD_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata ({in_pc, in_instruction}),
    .raddr (rptr),
    .rdata (head_data)
  );

  // Head entry is presented combinationally; forced to zero/NOP when empty.
  always_comb begin
    out_pc          = '0;
    out_instruction = WORD_W'(NOP_INSTRUCTION);
    if (out_valid) begin
      out_pc          = head_data[2*WORD_W-1:WORD_W];
      out_instruction = head_data[WORD_W-1:0];
    end
  end

endmodule
